// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver that samples each bit at its centre after a synchronized start edge.
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   rx        serial line, idle high, asynchronous to clk
//   data      last correctly framed byte, held until the next good frame
//   valid     one-cycle strobe, data updated this cycle
//   frame_err one-cycle strobe, stop bit sampled low
//   busy_flag high whenever the receiver is not idle
module uart_rx #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int CLK_COUNT_BIT  = CLK_FREQ / BAUD_RATE,
    parameter int CLK_COUNT_HALF = CLK_COUNT_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy_flag
);
    localparam logic [31:0] HALF_END = 32'(CLK_COUNT_HALF - 1);
    localparam logic [31:0] BIT_END  = 32'(CLK_COUNT_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t      state, state_n;
    logic        rx_m, rx_s;
    logic [31:0] clk_count, clk_count_n;
    logic [2:0]  bit_count, bit_count_n;
    logic [7:0]  shift, shift_n, data_n;
    logic        valid_n, frame_err_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            clk_count <= '0;
            bit_count <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            rx_m      <= rx;
            rx_s      <= rx_m;
            clk_count <= clk_count_n;
            bit_count <= bit_count_n;
            shift     <= shift_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
        end
    end

    // Leaving STOP at the stop-bit centre leaves half a bit to catch a back-to-back start edge.
    always_comb begin
        state_n     = state;
        clk_count_n = clk_count + 32'd1;
        bit_count_n = bit_count;
        shift_n     = shift;
        data_n      = data;
        valid_n     = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            IDLE: begin
                clk_count_n = '0;
                bit_count_n = '0;
                state_n     = rx_s ? IDLE : START;
            end
            START: begin
                if (clk_count == HALF_END) begin
                    clk_count_n = '0;
                    state_n     = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_count == BIT_END) begin
                    clk_count_n = '0;
                    shift_n     = {rx_s, shift[7:1]};
                    bit_count_n = bit_count + 3'd1;
                    state_n     = (bit_count == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                if (clk_count == BIT_END) begin
                    clk_count_n = '0;
                    data_n      = rx_s ? shift : data;
                    valid_n     = rx_s;
                    frame_err_n = !rx_s;
                    state_n     = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                clk_count_n = '0;
                state_n     = rx_s ? IDLE : BREAK;
            end
            default: begin
                clk_count_n = '0;
                state_n     = IDLE;
            end
        endcase
    end

    assign busy_flag = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a byte scoreboard popped on each valid strobe.
module tb_uart_rx;
    localparam int BIT = 434;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, busy_flag;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int valid_cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int pushed = 0;
    logic [7:0] exp_q[$];

    uart_rx dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data(data),
        .valid(valid),
        .frame_err(frame_err),
        .busy_flag(busy_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && frame_err)
                check("strobe_overlap", 32'(valid & frame_err), 32'd0);
            if (frame_err)
                ferr_cnt++;
            if (valid) begin
                valid_cnt++;
                valid_cyc = cyc;
                if (exp_q.size() == 0)
                    check("unexpected_valid", 32'(data), 32'hFFFF_FFFF);
                else
                    check("scoreboard_data", 32'(data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int bc, input logic stop_bit, input bit push);
        if (push) begin
            exp_q.push_back(b);
            pushed++;
        end
        start_cyc = cyc;
        rx = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bc) @(negedge clk);
        end
        rx = stop_bit;
        repeat (bc) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int v0, f0, lat;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(data), 32'h00);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy_flag), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        v0 = valid_cnt; f0 = ferr_cnt;
        fork
            send_byte(8'h55, BIT, 1'b1, 1'b1);
            begin
                @(negedge clk);
                check("busy_early", 32'(busy_flag), 32'd0);
                repeat (2) @(negedge clk);
                check("busy_started", 32'(busy_flag), 32'd1);
            end
        join
        drain("drain_55");
        lat = valid_cyc - start_cyc;
        check("latency_55", 32'(lat >= 4123 && lat <= 4127), 32'd1);
        check("busy_after_55", 32'(busy_flag), 32'd0);
        check("valid_cnt_55", 32'(valid_cnt - v0), 32'd1);
        check("ferr_55", 32'(ferr_cnt - f0), 32'd0);

        v0 = valid_cnt; f0 = ferr_cnt;
        send_byte(8'h3C, BIT, 1'b0, 1'b0);
        repeat (20 * BIT) @(negedge clk);
        check("break_busy", 32'(busy_flag), 32'd1);
        check("break_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("break_valid", 32'(valid_cnt - v0), 32'd0);
        check("break_data_held", 32'(data), 32'h55);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("break_busy_release", 32'(busy_flag), 32'd0);
        send_byte(8'h81, BIT, 1'b1, 1'b1);
        drain("drain_81");
        check("break_ferr_total", 32'(ferr_cnt - f0), 32'd1);

        v0 = valid_cnt; f0 = ferr_cnt;
        send_byte(8'hA3, BIT, 1'b1, 1'b1);
        send_byte(8'h00, BIT, 1'b1, 1'b1);
        drain("drain_b2b");
        check("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd2);
        check("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);

        v0 = valid_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (130) @(negedge clk);
        check("glitch_busy", 32'(busy_flag), 32'd0);
        repeat (500) @(negedge clk);
        check("glitch_valid", 32'(valid_cnt - v0), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

        v0 = valid_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BIT + BIT / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_ferr", 32'(frame_err), 32'd0);
        check("midrst_busy", 32'(busy_flag), 32'd0);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        repeat (2000) @(negedge clk);
        check("midrst_no_strobe", 32'(valid_cnt - v0 + ferr_cnt - f0), 32'd0);
        check("midrst_idle", 32'(busy_flag), 32'd0);
        send_byte(8'h12, BIT, 1'b1, 1'b1);
        drain("drain_12");

        send_byte(8'hC9, 417, 1'b1, 1'b1);
        drain("drain_fast");
        check("fast_data", 32'(data), 32'hC9);
        repeat (50) @(negedge clk);
        send_byte(8'hC9, 452, 1'b1, 1'b1);
        drain("drain_slow");
        check("slow_data", 32'(data), 32'hC9);

        repeat (100) @(negedge clk);
        check("valid_total", 32'(valid_cnt), 32'(pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
